// File: rtl/axis_pkt_m.sv
// -----------------------------------------------------------------------------
// axis_pkt_m - AXI-Stream packet master.
//
// Buffers source words in an internal FIFO, or generates a seeded ramp
// pattern (seed * beat index), and emits packets of (pkt_len + 1) beats with
// tlast on the final beat. The beat register (tvalid/tdata/tlast) is fully
// registered and holds stable under back-pressure.
//
// Ports:
//   m_axis_aclk / m_axis_areset : clock, asynchronous active-high reset
//   in_valid / in_data / in_ready : source word push interface (in_ready = !full)
//   start / mode / pkt_len / pat_seed : packet request, latched in IDLE
//   m_axis_tready / tvalid / tdata / tlast : AXI-Stream master port
//   busy       : state != IDLE
//   pkt_done   : one-cycle pulse after the final beat handshake
//   fifo_level : current FIFO occupancy
// -----------------------------------------------------------------------------
module axis_pkt_m #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 8
) (
  input  logic                          m_axis_aclk,
  input  logic                          m_axis_areset,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  input  logic                          start,
  input  logic                          mode,
  input  logic [LEN_W-1:0]              pkt_len,
  input  logic [DATA_W-1:0]             pat_seed,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tvalid,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          busy,
  output logic                          pkt_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  // One extra bit so a 2^LEN_W-beat packet can reach idx == len without wrapping.
  localparam int IW    = LEN_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic              mode_q,   mode_d;
  logic [LEN_W-1:0]  len_q,    len_d;
  logic [DATA_W-1:0] seed_q,   seed_d;
  logic [IW-1:0]     idx_q,    idx_d;
  logic [DATA_W-1:0] pat_q,    pat_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q,  level_d;
  logic              tvalid_q, tvalid_d;
  logic [DATA_W-1:0] tdata_q,  tdata_d;
  logic              tlast_q,  tlast_d;
  logic              done_q,   done_d;
  logic              busy_q,   busy_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic full_s, empty_s, load_s, pop_s, push_s, hs_s, last_s;

  assign full_s   = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty_s  = (level_q == '0);
  assign in_ready = ~full_s;
  assign hs_s     = tvalid_q & m_axis_tready;
  assign last_s   = (idx_q == {1'b0, len_q});
  // Pattern mode never starves; FIFO mode needs a word already stored.
  assign load_s   = (state_q == S_SEND) & (mode_q | ~empty_s) & (~tvalid_q | m_axis_tready);
  assign pop_s    = load_s & ~mode_q;
  // A full FIFO still takes a word on an edge where it also pops one.
  assign push_s   = in_valid & (~full_s | pop_s);

  // Next-state logic for the FIFO bookkeeping, beat register and packet FSM.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    seed_d   = seed_q;
    idx_d    = idx_q;
    pat_d    = pat_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    done_d   = 1'b0;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (load_s) begin
      tvalid_d = 1'b1;
      tdata_d  = mode_q ? pat_q : mem_q[rd_ptr_q];
      tlast_d  = last_s;
      idx_d    = idx_q + IW'(1);
      // Running sum seed*idx avoids a multiplier.
      pat_d    = pat_q + seed_q;
    end else if (hs_s) begin
      tvalid_d = 1'b0;
      tdata_d  = '0;
      tlast_d  = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEND;
          mode_d  = mode;
          len_d   = pkt_len;
          seed_d  = pat_seed;
          idx_d   = '0;
          pat_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (load_s && last_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_SEND;
        end
      end
      S_DRAIN: begin
        if (hs_s && tlast_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers; reset aborts any packet in flight.
  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      len_q    <= '0;
      seed_q   <= '0;
      idx_q    <= '0;
      pat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      seed_q   <= seed_d;
      idx_q    <= idx_d;
      pat_q    <= pat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers and level are flushed.
  always_ff @(posedge m_axis_aclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign pkt_done      = done_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_axis_pkt_m.sv
module tb_axis_pkt_m;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          in_ready;
  logic          start    = 1'b0;
  logic          mode     = 1'b0;
  logic [LW-1:0] pkt_len  = '0;
  logic [DW-1:0] pat_seed = '0;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          busy;
  logic          pkt_done;
  logic [4:0]    fifo_level;

  axis_pkt_m #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .start         (start),
    .mode          (mode),
    .pkt_len       (pkt_len),
    .pat_seed      (pat_seed),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .pkt_done      (pkt_done),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model (packet-level view) ----------------
  int unsigned mq[$];     // words held in the FIFO
  bit  m_busy;            // packet in progress
  int  m_idx, m_len, m_seed;
  bit  m_mode;
  bit  m_v, m_last, m_done;
  int  m_d;

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_idx = 0; m_len = 0; m_seed = 0; m_mode = 0;
    m_v = 0; m_last = 0; m_done = 0; m_d = 0;
  endtask

  task automatic model_step();
    bit hs, ld, pop, push, fin;
    hs   = m_v && m_axis_tready;
    ld   = m_busy && (m_idx <= m_len) && (m_mode || mq.size() > 0) && (!m_v || m_axis_tready);
    pop  = ld && !m_mode;
    push = in_valid && ((mq.size() < DEPTH) || pop);
    fin  = hs && m_last;
    if (ld) begin
      if (m_mode) m_d = (m_seed * m_idx) % (1 << DW);
      else        m_d = int'(mq.pop_front());
      m_last = (m_idx == m_len);
      m_v    = 1;
      m_idx++;
    end else if (hs) begin
      m_v = 0; m_d = 0; m_last = 0;
    end
    if (push) mq.push_back(int'(in_data));
    m_done = fin;
    if (fin) m_busy = 0;
    else if (!m_busy && start) begin
      m_busy = 1; m_mode = mode; m_len = int'(pkt_len); m_seed = int'(pat_seed); m_idx = 0;
    end
  endtask

  // ---------------- cycle driver ----------------
  int hs_d[$];
  bit hs_l[$];
  int done_cnt = 0;
  int exp_q[$];

  task automatic tick();
    if (m_axis_tvalid && m_axis_tready) begin
      hs_d.push_back(int'(m_axis_tdata));
      hs_l.push_back(m_axis_tlast);
    end
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    chk("tvalid",   32'(m_axis_tvalid), 32'(m_v));
    chk("tdata",    32'(m_axis_tdata),  32'(m_d));
    chk("tlast",    32'(m_axis_tlast),  32'(m_last));
    chk("busy",     32'(busy),          32'(m_busy));
    chk("pkt_done", 32'(pkt_done),      32'(m_done));
    chk("in_ready", 32'(in_ready),      32'(mq.size() < DEPTH));
    chk("level",    32'(fifo_level),    32'(mq.size()));
    if (pkt_done) done_cnt++;
  endtask

  task automatic clear_log();
    hs_d.delete(); hs_l.delete(); exp_q.delete(); done_cnt = 0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    chk({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  // compares handshaken beats with exp_q; tlast only on the final beat
  task automatic chk_seq(input string tag);
    chk({tag, "_beats"}, 32'(hs_d.size()), 32'(exp_q.size()));
    for (int i = 0; i < hs_d.size() && i < exp_q.size(); i++) begin
      chk({tag, "_data"}, 32'(hs_d[i]), 32'(exp_q[i]));
      chk({tag, "_last"}, 32'(hs_l[i]), 32'(i == exp_q.size() - 1));
    end
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic begin_pkt(input bit md, input int len, input int seed);
    start = 1'b1; mode = md; pkt_len = LW'(len); pat_seed = DW'(seed);
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    tick(); tick();
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_inready", 32'(in_ready), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    tick();

    // pattern, len 3, seed 5
    clear_log();
    m_axis_tready = 1'b1;
    begin_pkt(1'b1, 3, 5);
    run_until_idle("pat5", 20);
    tick();
    exp_q = '{0, 5, 10, 15};
    chk_seq("pat5");

    // FIFO mode, tready toggling
    clear_log();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = DW'(8'hA1 + i); tick();
    end
    in_valid = 1'b0;
    m_axis_tready = 1'b1;
    begin_pkt(1'b0, 3, 0);
    for (int n = 0; n < 40 && busy; n++) begin
      m_axis_tready = ~m_axis_tready; tick();
    end
    m_axis_tready = 1'b1;
    run_until_idle("fifo", 10);
    tick();
    exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    chk_seq("fifo");
    chk("fifo_level_end", 32'(fifo_level), 32'd0);

    // FIFO underrun mid-packet
    clear_log();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = DW'(8'hC1 + i); tick();
    end
    in_valid = 1'b0;
    begin_pkt(1'b0, 3, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("underrun_gap", 32'(m_axis_tvalid), 32'd0);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = DW'(8'hC3 + i); tick();
    end
    in_valid = 1'b0;
    run_until_idle("under", 20);
    tick();
    exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    chk_seq("under");

    // FIFO full, then push on every pop edge
    clear_log();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = DW'(8'hB0 + i); tick();
    end
    in_valid = 1'b0;
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_inready", 32'(in_ready), 32'd0);
    begin_pkt(1'b0, 15, 0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = DW'(8'hD0 + i); tick();
    end
    in_valid = 1'b0;
    chk("full_hold_level", 32'(fifo_level), 32'd16);
    run_until_idle("full", 40);
    tick();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'hB0 + i);
    chk_seq("full");

    // pattern seed 0x80, 256 beats, start during SEND ignored
    clear_log();
    begin_pkt(1'b1, 255, 8'h80);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; mode = 1'b0; pkt_len = 8'd0; tick();
    end
    start = 1'b0;
    run_until_idle("wrap", 400);
    tick();
    for (int i = 0; i < 256; i++) exp_q.push_back((i % 2) ? 8'h80 : 8'h00);
    chk_seq("wrap");

    // asynchronous reset mid-packet
    clear_log();
    m_axis_tready = 1'b0;
    begin_pkt(1'b1, 10, 3);
    tick();
    chk("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("arst_tlast",  32'(m_axis_tlast),  32'd0);
    chk("arst_busy",   32'(busy),          32'd0);
    chk("arst_level",  32'(fifo_level),    32'd0);
    chk("arst_inready", 32'(in_ready),     32'd1);
    model_reset();
    tick();
    rst = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    clear_log();
    begin_pkt(1'b1, 2, 7);
    run_until_idle("post_rst", 20);
    tick();
    exp_q = '{0, 7, 14};
    chk_seq("post_rst");

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      in_valid      = 1'($urandom_range(0, 1));
      in_data       = DW'($urandom);
      start         = ($urandom_range(0, 7) == 0);
      mode          = 1'($urandom_range(0, 1));
      pkt_len       = LW'($urandom_range(0, 6));
      pat_seed      = DW'($urandom);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    start = 1'b0;
    m_axis_tready = 1'b1;
    for (int n = 0; n < 300 && busy; n++) begin
      in_valid = 1'b1; in_data = DW'($urandom); tick();
    end
    in_valid = 1'b0;
    chk("rand_drain_timeout", 32'(busy), 32'd0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axis_pkt_m.md
# axis_pkt_m

Parametrised AXI-Stream packet master, the successor to our fixed 4-beat 8-bit stream master. It buffers source words in an internal FIFO, or generates a seeded ramp pattern, and emits packets of programmable length with `tlast` on the final beat. It sits between a local data producer and any AXI-Stream slave in the design. Outputs are fully registered and hold stable under back-pressure.

## Interface
- `DATA_W`, 8: width of `in_data`, `pat_seed`, `m_axis_tdata`.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `LEN_W`, 8: width of `pkt_len`; max packet is 2^LEN_W beats.

Ports:
- `m_axis_aclk`  in  1  sole clock.
- `m_axis_areset`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  source word valid.
- `in_data`  in  DATA_W  source word.
- `in_ready`  out  1  FIFO can accept: `!full`.
- `start`  in  1  packet request, sampled only in IDLE.
- `mode`  in  1  0 = FIFO data, 1 = pattern; latched at start.
- `pkt_len`  in  LEN_W  packet length minus one; latched at start.
- `pat_seed`  in  DATA_W  pattern seed; latched at start.
- `m_axis_tready`  in  1  slave ready.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tdata`  out  DATA_W  beat data.
- `m_axis_tlast`  out  1  final beat of packet.
- `busy`  out  1  state ≠ IDLE.
- `pkt_done`  out  1  one-cycle pulse after the final beat handshake.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset: all outputs 0, except `in_ready` = 1 (FIFO empty). FIFO is flushed, state goes to IDLE, index goes to 0. Reset mid-packet aborts the packet; no `tlast` or `pkt_done` is produced.
- FIFO push on `in_valid && in_ready`. Pushes are accepted in every state.
- FIFO pop when a FIFO-mode beat loads into the output register.
- Push and pop in the same edge leaves `fifo_level` unchanged. A full FIFO still pushes that edge only if it pops in the same edge; otherwise `in_ready` = 0 blocks the push.
- States:
  - IDLE: on `start`, latch `mode`, `len` = `pkt_len`, `seed` = `pat_seed`, set `idx` = 0, and go to SEND.
  - SEND: issue beats. When the beat with `idx == len` loads, go to DRAIN.
  - DRAIN: wait for the `tlast` handshake, then go to IDLE and pulse `pkt_done`.
- `start` is ignored outside IDLE.
- Beat load condition: state = SEND, source available, and (`!tvalid || tready`).
  - Pattern mode: the source is always available.
  - FIFO mode: the source is available when `fifo_level` (pre-edge) is nonzero.
- Loaded beat:
  - Pattern: `tdata` = (`seed` × `idx`) mod 2^DATA_W.
  - FIFO: `tdata` = FIFO head.
  - `tlast` = (`idx == len`).
  - `idx` increments after each load.
- On a handshake (`tvalid && tready`) with no new load, `tvalid`, `tdata` and `tlast` are cleared to 0. `tdata` is 0 whenever `tvalid` = 0.
- While `tvalid && !tready`, `tdata`/`tlast` hold stable and `tvalid` never drops (AXI rule).
- FIFO empty mid-packet in FIFO mode: `tvalid` deasserts after the pending beat is taken. Transmission resumes when data arrives; the packet is not terminated.
- `pkt_len` = 0 gives a 1-beat packet with `tlast` on beat 0. `pkt_len` = 2^LEN_W−1 gives 2^LEN_W beats; `idx` must not wrap before the compare.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are derived from `fifo_level`.

## Timing
- `start` sampled at edge E: `busy` goes high after E. The first beat loads at E+1 if the source is available, so `tvalid` is visible after E+1.
- FIFO mode: a word pushed at edge P is poppable at P+1 at the earliest.
- With `tready` held at 1 and the source available, throughput is 1 beat/cycle. An N-beat packet occupies edges E+1…E+N; the handshake on the last beat occurs at edge E+N+1.
- Final handshake at edge H: state = IDLE and `busy` = 0 after H; `pkt_done` = 1 for the cycle after H. The next `start` is accepted at H+1 at the earliest.
- No combinational path from `m_axis_tready` to `m_axis_tvalid`/`m_axis_tdata`. `in_ready` depends only on registered state.

## Test plan
- Pattern, `pkt_len` = 3, `seed` = 5, `tready` = 1 -> `tdata` 0, 5, 10, 15 on consecutive cycles; `tlast` only on 15; one `pkt_done` pulse.
- FIFO mode: push 0xA1..0xA4, `pkt_len` = 3, `tready` toggling 1,0,1,0 -> data in order, held stable during `tready` = 0; `fifo_level` ends at 0.
- FIFO underrun: push 2 words, `pkt_len` = 3, then push 2 more 5 cycles later -> `tvalid` gap, 4 beats total, `tlast` on beat 4 only.
- FIFO full: 17 pushes with `DEPTH` = 16 and no packet -> `in_ready` = 0 after 16 pushes, `fifo_level` = 16. Then start FIFO mode with a push on the same edge as each pop -> level stays 16 until pushes stop.
- Pattern, `seed` = 0x80, `pkt_len` = 255 -> `tdata` alternates 0x00/0x80 (mod wrap); `tlast` on beat 256; `start` during SEND ignored.
- Assert `m_axis_areset` mid-packet with `tvalid` = 1 -> all outputs 0 immediately (asynchronous), `fifo_level` = 0; a new packet runs normally after release.
